// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared types and constants for the MEM pipeline stage.
// Holds the MemOp encodings, the MEM FSM state encodings, the register-file
// widths reused from the core, and small decode helpers for MemOp codes.
package mem_access_pkg;

  localparam int RegLen     = 32;
  localparam int RegAddrLen = 5;

  localparam logic [RegLen-1:0] ZERO_WORD    = '0;
  localparam logic              WriteDisable = 1'b0;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_LB  = 4'd1,
    OP_LH  = 4'd2,
    OP_LW  = 4'd3,
    OP_LBU = 4'd4,
    OP_LHU = 4'd5,
    OP_SB  = 4'd6,
    OP_SH  = 4'd7,
    OP_SW  = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Number of bytes moved by a MemOp; 0 for anything that is not a memory op.
  function automatic logic [2:0] op_bytes(input logic [3:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 3'd1;
      OP_LH, OP_LHU, OP_SH: return 3'd2;
      OP_LW, OP_SW:         return 3'd4;
      default:              return 3'd0;
    endcase
  endfunction

  function automatic logic op_is_load(input logic [3:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mem_access_load_extend.sv
// mem_access_load_extend: the load_extend unit; turns the little-endian byte
// capture buffer into the 32-bit write-back value for the given load op.
// Ports: buf_i (captured bytes), op_i (MemOp code), data_o (extended value).
module mem_access_load_extend
  import mem_access_pkg::*;
(
  input  logic [RegLen-1:0] buf_i,
  input  logic [3:0]        op_i,
  output logic [RegLen-1:0] data_o
);

  always_comb begin
    data_o = ZERO_WORD;
    case (op_i)
      OP_LB:   data_o = {{24{buf_i[7]}}, buf_i[7:0]};
      OP_LH:   data_o = {{16{buf_i[15]}}, buf_i[15:0]};
      OP_LW:   data_o = buf_i;
      OP_LBU:  data_o = {24'h0, buf_i[7:0]};
      OP_LHU:  data_o = {16'h0, buf_i[15:0]};
      default: data_o = ZERO_WORD;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// mem_access: MEM stage of the RV32I pipeline. ALU results pass through
// combinationally; loads/stores run byte-serially on the 8-bit RAM port while
// mem_stall_req freezes the pipeline. Ports: ex_* from ex_mem, mem_rd_* to
// mem_wb, mem_stall_req to the stall controller, ram_* to the RAM arbiter.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [RegLen-1:0]     ex_rd_data,
  input  logic [RegAddrLen-1:0] ex_rd_addr,
  input  logic                  ex_rd_enable,
  input  logic [3:0]            ex_mem_op,
  input  logic [RegLen-1:0]     ex_store_data,
  output logic [RegLen-1:0]     mem_rd_data,
  output logic [RegAddrLen-1:0] mem_rd_addr,
  output logic                  mem_rd_enable,
  output logic                  mem_stall_req,
  output logic                  ram_req,
  output logic                  ram_wr,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [7:0]            ram_wdata,
  input  logic                  ram_grant,
  input  logic [7:0]            ram_rdata
);

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;       // index of the next byte to request
  logic [RegLen-1:0] buf_q, buf_d;       // little-endian load capture buffer
  logic              rd_pend_q, rd_pend_d; // last cycle had a granted read

  logic [2:0]        nbytes;
  logic              is_load, is_store, is_mem, last_byte;
  logic [1:0]        cap_idx;
  logic [RegLen-1:0] load_val;

  assign nbytes   = op_bytes(ex_mem_op);
  assign is_load  = op_is_load(ex_mem_op);
  assign is_store = op_is_store(ex_mem_op);
  assign is_mem   = is_load | is_store;
  // cnt_q is 0 in IDLE, so this also flags single-byte ops on the first request.
  assign last_byte = (cnt_q == nbytes - 3'd1);
  // Byte granted last cycle sits one below the (already advanced) counter;
  // cnt_q = 4 wraps to index 3 through the 2-bit truncation.
  assign cap_idx  = cnt_q[1:0] - 2'd1;

  mem_access_load_extend u_load_extend (
    .buf_i  (buf_q),
    .op_i   (ex_mem_op),
    .data_o (load_val)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      buf_q     <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      buf_q     <= buf_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    buf_d         = buf_q;
    mem_rd_data   = ZERO_WORD;
    mem_rd_addr   = '0;
    mem_rd_enable = WriteDisable;
    mem_stall_req = 1'b0;
    ram_req       = 1'b0;
    ram_wr        = 1'b0;
    ram_addr      = '0;
    ram_wdata     = '0;

    // Read data arrives one cycle after its grant, in whatever state we are in.
    if (rd_pend_q) begin
      buf_d[{cap_idx, 3'b000} +: 8] = ram_rdata;
    end

    case (state_q)
      ST_IDLE, ST_BUSY: begin
        if (state_q == ST_BUSY || is_mem) begin
          mem_stall_req = 1'b1;
          ram_req       = 1'b1;
          ram_wr        = is_store;
          ram_addr      = ADDR_W'(ex_rd_data) + ADDR_W'(cnt_q);
          ram_wdata     = is_store ? ex_store_data[{cnt_q[1:0], 3'b000} +: 8] : 8'h00;
          if (ram_grant) begin
            cnt_d = cnt_q + 3'd1;
            if (last_byte) begin
              state_d = is_load ? ST_DRAIN : ST_DONE;
            end else begin
              state_d = ST_BUSY;
            end
          end
        end else begin
          mem_rd_data   = ex_rd_data;
          mem_rd_addr   = ex_rd_addr;
          mem_rd_enable = ex_rd_enable;
        end
      end
      ST_DRAIN: begin
        mem_stall_req = 1'b1;
        state_d       = ST_DONE;
      end
      ST_DONE: begin
        if (is_load) begin
          mem_rd_data   = load_val;
          mem_rd_addr   = ex_rd_addr;
          mem_rd_enable = ex_rd_enable;
        end
        // ex_mem advances on this edge, so returning to IDLE cannot re-trigger.
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase

    rd_pend_d = ram_req & ram_grant & ~ram_wr;

    // Outputs are forced quiet for as long as reset is held.
    if (rst) begin
      mem_rd_data   = ZERO_WORD;
      mem_rd_addr   = '0;
      mem_rd_enable = WriteDisable;
      mem_stall_req = 1'b0;
      ram_req       = 1'b0;
      ram_wr        = 1'b0;
      ram_addr      = '0;
      ram_wdata     = '0;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed bench for mem_access with a byte-wide RAM model.
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ex_rd_data = '0;
  logic [4:0]  ex_rd_addr = '0;
  logic        ex_rd_enable = 1'b0;
  logic [3:0]  ex_mem_op = '0;
  logic [31:0] ex_store_data = '0;
  logic [31:0] mem_rd_data;
  logic [4:0]  mem_rd_addr;
  logic        mem_rd_enable;
  logic        mem_stall_req;
  logic        ram_req;
  logic        ram_wr;
  logic [31:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_grant = 1'b1;
  logic [7:0]  ram_rdata = 8'hEE;

  int n_cmp = 0;
  int n_fail = 0;

  logic [7:0] ram [logic [31:0]];

  mem_access #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .ex_rd_data(ex_rd_data), .ex_rd_addr(ex_rd_addr), .ex_rd_enable(ex_rd_enable),
    .ex_mem_op(ex_mem_op), .ex_store_data(ex_store_data),
    .mem_rd_data(mem_rd_data), .mem_rd_addr(mem_rd_addr), .mem_rd_enable(mem_rd_enable),
    .mem_stall_req(mem_stall_req),
    .ram_req(ram_req), .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_grant(ram_grant), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM model: writes land at the granted edge, read data is valid the next cycle.
  always @(posedge clk) begin
    if (ram_req && ram_grant && ram_wr) begin
      ram[ram_addr] = ram_wdata;
    end
    if (ram_req && ram_grant && !ram_wr) begin
      ram_rdata <= ram.exists(ram_addr) ? ram[ram_addr] : 8'h00;
    end else begin
      ram_rdata <= 8'hEE;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
                       input logic [4:0] rd, input logic en);
    ex_mem_op = op; ex_rd_data = a; ex_store_data = sd; ex_rd_addr = rd; ex_rd_enable = en;
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, " stall"},   32'(mem_stall_req), 32'h0);
    chk({nm, " ram_req"}, 32'(ram_req),       32'h0);
    chk({nm, " ram_addr"}, ram_addr,          32'h0);
    chk({nm, " rd_data"}, mem_rd_data,        32'h0);
    chk({nm, " rd_en"},   32'(mem_rd_enable), 32'h0);
    chk({nm, " rd_addr"}, 32'(mem_rd_addr),   32'h0);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [4:0]  rd;
    logic        en;
    logic [31:0] exp_data;
    logic        exp_en;
    int          exp_stall;
  } vec_t;

  // Applies one op (starting just after a falling edge), counts stall cycles,
  // checks the result cycle, then returns the inputs to NOP.
  task automatic run_vec(input vec_t v, input string nm);
    int st;
    st = 0;
    drive(v.op, v.addr, v.sdata, v.rd, v.en);
    #1;
    while (mem_stall_req && st < 20) begin
      st++;
      @(negedge clk); #1;
    end
    chk({nm, " stall_cycles"}, 32'(st), 32'(v.exp_stall));
    chk({nm, " rd_data"}, mem_rd_data, v.exp_data);
    chk({nm, " rd_en"}, 32'(mem_rd_enable), 32'(v.exp_en));
    if (v.exp_en) chk({nm, " rd_addr"}, 32'(mem_rd_addr), 32'(v.rd));
    @(negedge clk);
    drive(OP_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
  endtask

  vec_t vecs[10];

  logic [31:0] sw_addr [5];
  logic [7:0]  sw_data [5];
  logic        sh_grant [4];
  logic [31:0] sh_addr [4];
  logic [7:0]  sh_data [4];
  logic        sh_req [4];

  initial begin
    ram[32'h100] = 8'h78; ram[32'h101] = 8'h56; ram[32'h102] = 8'h34; ram[32'h103] = 8'h12;
    ram[32'h200] = 8'h80;
    ram[32'h210] = 8'h01; ram[32'h211] = 8'h80;

    //         op      addr          store          rd     en    exp_data       exp_en stall
    vecs[0] = '{OP_NOP, 32'h1234,     32'h0,         5'd5,  1'b1, 32'h00001234, 1'b1, 0};
    vecs[1] = '{OP_LW,  32'h100,      32'h0,         5'd1,  1'b1, 32'h12345678, 1'b1, 5};
    vecs[2] = '{OP_LB,  32'h200,      32'h0,         5'd2,  1'b1, 32'hFFFFFF80, 1'b1, 2};
    vecs[3] = '{OP_LBU, 32'h200,      32'h0,         5'd3,  1'b1, 32'h00000080, 1'b1, 2};
    vecs[4] = '{OP_LH,  32'h210,      32'h0,         5'd4,  1'b1, 32'hFFFF8001, 1'b1, 3};
    vecs[5] = '{OP_LHU, 32'h210,      32'h0,         5'd6,  1'b1, 32'h00008001, 1'b1, 3};
    vecs[6] = '{OP_SB,  32'h400,      32'h11223344,  5'd7,  1'b1, 32'h00000000, 1'b0, 1};
    vecs[7] = '{OP_SW,  32'h500,      32'hCAFEBABE,  5'd8,  1'b1, 32'h00000000, 1'b0, 4};
    vecs[8] = '{OP_LW,  32'h500,      32'h0,         5'd9,  1'b1, 32'hCAFEBABE, 1'b1, 5};
    vecs[9] = '{OP_LH,  32'h102,      32'h0,         5'd10, 1'b1, 32'h00001234, 1'b1, 3};

    sw_addr = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h1, 32'h0};
    sw_data = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
    sh_grant = '{1'b1, 1'b0, 1'b1, 1'b1};
    sh_req   = '{1'b1, 1'b1, 1'b1, 1'b0};
    sh_addr  = '{32'h300, 32'h301, 32'h301, 32'h0};
    sh_data  = '{8'hDD, 8'hCC, 8'hCC, 8'h00};

    // Reset holds every output low even with a memory op presented.
    @(negedge clk);
    drive(OP_LW, 32'h100, 32'h0, 5'd1, 1'b1);
    #1;
    chk_quiet("reset");
    @(negedge clk);
    rst = 1'b0;
    drive(OP_NOP, 32'h0, 32'h0, 5'd0, 1'b0);

    // NOP pass-through is same-cycle and never touches the RAM.
    @(negedge clk);
    drive(OP_NOP, 32'h1234, 32'h0, 5'd5, 1'b1);
    #1;
    chk("nop ram_req", 32'(ram_req), 32'h0);
    chk("nop stall", 32'(mem_stall_req), 32'h0);

    // Table of ops with full grant.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end
    chk("sb ram[400]", 32'(ram[32'h400]), 32'h44);

    // LW cycle by cycle: addresses 0x100..0x103 in cycles 0-3, stall 0-4, result in 5.
    @(negedge clk);
    drive(OP_LW, 32'h100, 32'h0, 5'd7, 1'b1);
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("lw c%0d ram_req", c), 32'(ram_req), (c < 4) ? 32'h1 : 32'h0);
      chk($sformatf("lw c%0d ram_addr", c), ram_addr, (c < 4) ? 32'h100 + 32'(c) : 32'h0);
      chk($sformatf("lw c%0d stall", c), 32'(mem_stall_req), (c < 5) ? 32'h1 : 32'h0);
      if (c == 5) begin
        chk("lw result", mem_rd_data, 32'h12345678);
        chk("lw en", 32'(mem_rd_enable), 32'h1);
        chk("lw rd_addr", 32'(mem_rd_addr), 32'd7);
      end
      @(negedge clk);
    end
    drive(OP_NOP, 32'h0, 32'h0, 5'd0, 1'b0);

    // SH with the grant withheld in cycle 1.
    @(negedge clk);
    drive(OP_SH, 32'h300, 32'hAABBCCDD, 5'd11, 1'b1);
    for (int c = 0; c < 4; c++) begin
      ram_grant = sh_grant[c];
      #1;
      chk($sformatf("sh c%0d ram_req", c), 32'(ram_req), 32'(sh_req[c]));
      chk($sformatf("sh c%0d ram_addr", c), ram_addr, sh_addr[c]);
      chk($sformatf("sh c%0d ram_wdata", c), 32'(ram_wdata), 32'(sh_data[c]));
      chk($sformatf("sh c%0d ram_wr", c), 32'(ram_wr), 32'(sh_req[c]));
      chk($sformatf("sh c%0d stall", c), 32'(mem_stall_req), (c < 3) ? 32'h1 : 32'h0);
      if (c == 3) chk("sh done en", 32'(mem_rd_enable), 32'h0);
      @(negedge clk);
    end
    ram_grant = 1'b1;
    drive(OP_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
    chk("sh ram[300]", 32'(ram[32'h300]), 32'hDD);
    chk("sh ram[301]", 32'(ram[32'h301]), 32'hCC);

    // SW across the top of the address space wraps to 0.
    @(negedge clk);
    drive(OP_SW, 32'hFFFFFFFE, 32'h01020304, 5'd12, 1'b1);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("sw c%0d ram_req", c), 32'(ram_req), (c < 4) ? 32'h1 : 32'h0);
      chk($sformatf("sw c%0d ram_addr", c), ram_addr, sw_addr[c]);
      chk($sformatf("sw c%0d ram_wdata", c), 32'(ram_wdata), 32'(sw_data[c]));
      @(negedge clk);
    end
    drive(OP_NOP, 32'h0, 32'h0, 5'd0, 1'b0);

    // Reset in cycle 2 of an LW abandons it; a following NOP passes through.
    @(negedge clk);
    drive(OP_LW, 32'h100, 32'h0, 5'd13, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_quiet("midrst");
    @(negedge clk);
    rst = 1'b0;
    drive(OP_NOP, 32'hABCD, 32'h0, 5'd3, 1'b1);
    #1;
    chk("post-rst nop data", mem_rd_data, 32'h0000ABCD);
    chk("post-rst nop addr", 32'(mem_rd_addr), 32'd3);
    chk("post-rst nop en", 32'(mem_rd_enable), 32'h1);
    chk("post-rst nop stall", 32'(mem_stall_req), 32'h0);
    chk("post-rst nop ram_req", 32'(ram_req), 32'h0);
    @(negedge clk);
    drive(OP_LB, 32'h200, 32'h0, 5'd14, 1'b1);
    #1;
    chk("post-rst lb first addr", ram_addr, 32'h200);
    run_vec(vecs[2], "post-rst lb");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
